simt_reconv_ctrl: RTL

//  Multi-level SIMT divergence/reconvergence controller for one core. It sequences a

---
 rtl/simt_pkg.sv | 32 +++
 rtl/simt_stack_mem.sv | 50 +++++
 rtl/simt_reconv_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/simt_pkg.sv
// Shared types and helpers for the SIMT divergence/reconvergence controller.
// Holds the stack entry payload, its phase encoding, the EXECUTE state code and
// the live-depth width helper.
package simt_pkg;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned MASK_W = 4;

  localparam logic [3:0] EXECUTE_STATE = 4'b0110;

  // ARMED: SSY pushed, no divergence yet; TAKEN: running taken path;
  // ELSE: running fall-through path.
  typedef enum logic [1:0] {
    ARMED = 2'd0,
    TAKEN = 2'd1,
    ELSE  = 2'd2
  } phase_e;

  typedef struct packed {
    logic [PC_W-1:0]   reconv_pc;
    logic [PC_W-1:0]   else_pc;
    logic [MASK_W-1:0] else_mask;
    logic [MASK_W-1:0] origin_mask;
    phase_e            phase;
  } reconv_entry_t;

  // Width needed to count 0..depth live entries.
  function automatic int unsigned depth_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/simt_stack_mem.sv
// Reconvergence stack storage: register array plus top pointer.
// Ports: clk, reset (sync, active-high); push + push_data, pop, write_top + top_wr
// (rewrite the top entry in place); top_rd (top entry, zero when empty);
// full, empty, depth (live entries, registered).
module simt_stack_mem #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   push,
  input  logic                                   pop,
  input  logic                                   write_top,
  input  simt_pkg::reconv_entry_t                push_data,
  input  simt_pkg::reconv_entry_t                top_wr,
  output simt_pkg::reconv_entry_t                top_rd,
  output logic                                   full,
  output logic                                   empty,
  output logic [simt_pkg::depth_w(DEPTH)-1:0]    depth
);
  import simt_pkg::*;

  localparam int unsigned DW = depth_w(DEPTH);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  reconv_entry_t entries [DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  assign top_idx  = IW'(depth - DW'(1));
  assign push_idx = IW'(depth);
  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign top_rd   = empty ? reconv_entry_t'('0) : entries[top_idx];

  // One operation per cycle; the controller never asserts more than one.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entries[i] <= reconv_entry_t'('0);
    end else if (push && !full) begin
      entries[push_idx] <= push_data;
      depth             <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end else if (write_top && !empty) begin
      entries[top_idx] <= top_wr;
    end
  end

endmodule

// File: rtl/simt_reconv_ctrl.sv
// SIMT divergence/reconvergence controller for one core.
// Decodes SSY / SYNC / BRnzp in EXECUTE, sequences the reconvergence stack,
// drives the per-thread active mask and issues one-cycle PC redirects.
// Ports: clk, reset (sync, active-high), enable, core_state, decoded_ssy,
// decoded_sync, decoded_branch, decoded_nzp, decoded_immediate, current_pc,
// thread_nzp (3 bits per thread) -> active_mask, pc_redirect, redirect_pc,
// stack_depth, sticky err_overflow / err_underflow / err_nosync.
module simt_reconv_ctrl #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = simt_pkg::PC_W,
  parameter int unsigned THREADS_PER_BLOCK     = simt_pkg::MASK_W,
  parameter int unsigned STACK_DEPTH           = 4,
  parameter logic [3:0]  EXECUTE_STATE         = simt_pkg::EXECUTE_STATE
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic [3:0]                                core_state,
  input  logic                                      decoded_ssy,
  input  logic                                      decoded_sync,
  input  logic                                      decoded_branch,
  input  logic [2:0]                                decoded_nzp,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]          decoded_immediate,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]          current_pc,
  input  logic [3*THREADS_PER_BLOCK-1:0]            thread_nzp,
  output logic [THREADS_PER_BLOCK-1:0]              active_mask,
  output logic                                      pc_redirect,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]          redirect_pc,
  output logic [simt_pkg::depth_w(STACK_DEPTH)-1:0] stack_depth,
  output logic                                      err_overflow,
  output logic                                      err_underflow,
  output logic                                      err_nosync
);
  import simt_pkg::*;

  localparam int unsigned T  = THREADS_PER_BLOCK;
  localparam int unsigned PW = PROGRAM_MEM_ADDR_BITS;

  logic          push, pop, write_top, full, empty;
  reconv_entry_t push_data, top_wr, top_rd;

  simt_stack_mem #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .write_top (write_top),
    .push_data (push_data),
    .top_wr    (top_wr),
    .top_rd    (top_rd),
    .full      (full),
    .empty     (empty),
    .depth     (stack_depth)
  );

  // reconv_pc is kept in each entry for debug visibility; control never reads it.
  logic unused_reconv_pc;
  assign unused_reconv_pc = ^top_rd.reconv_pc;

  logic          ev_ok, ssy_ev, sync_ev, br_ev;
  logic [T-1:0]  taken;
  logic [T-1:0]  mask_n;
  logic          redir_n, ovf_n, unf_n, nos_n;
  logic [PW-1:0] rpc_n;

  // Strobe priority: ssy > sync > branch.
  assign ev_ok   = enable && (core_state == EXECUTE_STATE);
  assign ssy_ev  = ev_ok && decoded_ssy;
  assign sync_ev = ev_ok && decoded_sync && !decoded_ssy;
  assign br_ev   = ev_ok && decoded_branch && !decoded_ssy && !decoded_sync;

  // Per-thread branch outcome, restricted to currently active threads.
  always_comb begin
    taken = '0;
    for (int t = 0; t < int'(T); t++)
      taken[t] = active_mask[t] && |(thread_nzp[3*t +: 3] & decoded_nzp);
  end

  // Next-state and stack-command decode.
  always_comb begin
    mask_n    = active_mask;
    redir_n   = 1'b0;
    rpc_n     = redirect_pc;
    ovf_n     = err_overflow;
    unf_n     = err_underflow;
    nos_n     = err_nosync;
    push      = 1'b0;
    pop       = 1'b0;
    write_top = 1'b0;
    top_wr    = top_rd;
    push_data = '{reconv_pc:   PC_W'(decoded_immediate),
                  else_pc:     '0,
                  else_mask:   '0,
                  origin_mask: MASK_W'(active_mask),
                  phase:       ARMED};

    if (ssy_ev) begin
      if (full) ovf_n = 1'b1;
      else      push  = 1'b1;
    end else if (sync_ev) begin
      if (empty) begin
        unf_n = 1'b1;
      end else if (top_rd.phase == TAKEN) begin
        // Taken path done: run the fall-through threads.
        mask_n       = T'(top_rd.else_mask);
        top_wr.phase = ELSE;
        write_top    = 1'b1;
        redir_n      = 1'b1;
        rpc_n        = PW'(top_rd.else_pc);
      end else begin
        mask_n = T'(top_rd.origin_mask);
        pop    = 1'b1;
      end
    end else if (br_ev && (taken != '0)) begin
      redir_n = 1'b1;
      rpc_n   = decoded_immediate;
      if (taken != active_mask) begin
        if (!empty && (top_rd.phase == ARMED)) begin
          top_wr.else_mask = MASK_W'(active_mask & ~taken);
          top_wr.else_pc   = PC_W'(current_pc + PW'(1));
          top_wr.phase     = TAKEN;
          write_top        = 1'b1;
          mask_n           = taken;
        end else begin
          // No armed reconvergence point: send every thread to the target.
          nos_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_mask   <= '1;
      pc_redirect   <= 1'b0;
      redirect_pc   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_nosync    <= 1'b0;
    end else begin
      active_mask   <= mask_n;
      pc_redirect   <= redir_n;
      redirect_pc   <= rpc_n;
      err_overflow  <= ovf_n;
      err_underflow <= unf_n;
      err_nosync    <= nos_n;
    end
  end

endmodule
